// File: rtl/harmonic_mixer.sv
// Harmonic mixer: sums one sine sample per harmonic each frame and emits a saturated mix.
// Optional per-harmonic rolloff scaling is enabled by defining HARMONIC_ROLLOFF_EN.
module harmonic_mixer #(
  parameter int ACC_WIDTH = 24,
  parameter int OUT_SHIFT = 4
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Sample_Tick,
  input  logic [7:0]  i_Harmonic_Count,
  output logic [7:0]  o_Harmonic,
  input  logic        i_Sample_Ready,
  input  logic [15:0] i_Sample_Value,
  output logic        o_Next_Sample,
  input  logic        i_Freq_Too_High,
  output logic [15:0] o_Mix,
  output logic        o_Mix_Valid,
  output logic        o_Busy,
  output logic        o_Overrun
);

  // state      | meaning
  // IDLE       | waiting for a sample tick
  // WAIT_READY | o_Harmonic presented, waiting for the generator
  // SETTLE     | one cycle of LUT output latency
  // CAPTURE    | accumulate sample, advance index, pulse o_Next_Sample
  // RELEASE    | wait for ready to drop before the next harmonic
  // OUTPUT     | shift, saturate and publish the mix
  typedef enum logic [2:0] {
    IDLE, WAIT_READY, SETTLE, CAPTURE, RELEASE, OUTPUT
  } state_t;

  localparam logic signed [ACC_WIDTH-1:0] MIX_MAX = ACC_WIDTH'(32'sd32767);
  localparam logic signed [ACC_WIDTH-1:0] MIX_MIN = ACC_WIDTH'(-32'sd32768);

  state_t                      state;
  logic signed [ACC_WIDTH-1:0] acc;
  logic [7:0]                  count_q;
  logic                        last_q;

  logic signed [ACC_WIDTH-1:0] sample_ext;
  logic signed [ACC_WIDTH-1:0] sample_scaled;
  logic signed [ACC_WIDTH-1:0] acc_shifted;
  logic                        is_last;
  logic [15:0]                 mix_sat;

`ifdef HARMONIC_ROLLOFF_EN
  function automatic logic [3:0] rolloff_shift(input logic [7:0] idx);
    logic [8:0] v;
    logic [3:0] r;
    v = {1'b0, idx} + 9'd1;
    r = '0;
    for (int i = 0; i < 9; i++)
      if (v[i]) r = 4'(i);
    return r;
  endfunction
`endif

  always_comb begin
    sample_ext = ACC_WIDTH'($signed(i_Sample_Value));
`ifdef HARMONIC_ROLLOFF_EN
    sample_scaled = sample_ext >>> rolloff_shift(o_Harmonic);
`else
    sample_scaled = sample_ext;
`endif
    is_last     = (o_Harmonic == count_q - 8'd1) || i_Freq_Too_High;
    acc_shifted = acc >>> OUT_SHIFT;
    if (acc_shifted > MIX_MAX)
      mix_sat = 16'h7FFF;
    else if (acc_shifted < MIX_MIN)
      mix_sat = 16'h8000;
    else
      mix_sat = acc_shifted[15:0];
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state         <= IDLE;
      acc           <= '0;
      count_q       <= 8'd1;
      last_q        <= 1'b0;
      o_Harmonic    <= '0;
      o_Next_Sample <= 1'b0;
      o_Mix         <= '0;
      o_Mix_Valid   <= 1'b0;
      o_Busy        <= 1'b0;
      o_Overrun     <= 1'b0;
    end else begin
      o_Next_Sample <= 1'b0;
      o_Mix_Valid   <= 1'b0;
      // A tick during a frame is dropped; the frame keeps running.
      if (i_Sample_Tick && state != IDLE)
        o_Overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (i_Sample_Tick) begin
            acc        <= '0;
            count_q    <= (i_Harmonic_Count == 8'd0) ? 8'd1 : i_Harmonic_Count;
            o_Harmonic <= '0;
            o_Busy     <= 1'b1;
            state      <= WAIT_READY;
          end
        end
        WAIT_READY: begin
          if (i_Sample_Ready)
            state <= SETTLE;
        end
        SETTLE: state <= CAPTURE;
        CAPTURE: begin
          if (!i_Freq_Too_High)
            acc <= acc + sample_scaled;
          o_Next_Sample <= 1'b1;
          last_q        <= is_last;
          o_Harmonic    <= is_last ? 8'd0 : o_Harmonic + 8'd1;
          state         <= RELEASE;
        end
        RELEASE: begin
          if (!i_Sample_Ready)
            state <= last_q ? OUTPUT : WAIT_READY;
        end
        OUTPUT: begin
          o_Mix       <= mix_sat;
          o_Mix_Valid <= 1'b1;
          o_Busy      <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          o_Busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_harmonic_mixer.sv
// Self-checking bench for harmonic_mixer: behavioural sample generator plus a mix scoreboard.
module tb_harmonic_mixer;
  logic        clk = 1'b0;
  logic        rst, tick, ready, too_high;
  logic [7:0]  hcount, harm;
  logic [15:0] sval, mix;
  logic        next, mix_valid, busy, overrun;

  int      n_checks = 0;
  int      n_pass   = 0;
  int      valid_cnt = 0;
  int      exp_q[$];
  shortint vals[256];

  always #5 clk = ~clk;

  harmonic_mixer #(.ACC_WIDTH(24), .OUT_SHIFT(4)) dut (
    .i_Clock          (clk),
    .i_Reset          (rst),
    .i_Sample_Tick    (tick),
    .i_Harmonic_Count (hcount),
    .o_Harmonic       (harm),
    .i_Sample_Ready   (ready),
    .i_Sample_Value   (sval),
    .o_Next_Sample    (next),
    .i_Freq_Too_High  (too_high),
    .o_Mix            (mix),
    .o_Mix_Valid      (mix_valid),
    .o_Busy           (busy),
    .o_Overrun        (overrun)
  );

  always @(negedge clk)
    if (mix_valid) valid_cnt++;

  task automatic check_val(input string tag, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  // Reference mix: stop at the flagged harmonic without adding it.
  function automatic int model_mix(input int cnt, input int th);
    longint acc;
    longint s;
    int     n, k;
    acc = 0;
    n = (cnt == 0) ? 1 : cnt;
    for (int h = 0; h < n; h++) begin
      if (h == th) break;
      s = longint'(vals[h]);
`ifdef HARMONIC_ROLLOFF_EN
      k = 0;
      while (((h + 1) >> (k + 1)) != 0) k++;
      s = s >>> k;
`else
      k = 0;
`endif
      acc += s;
    end
    acc = acc >>> 4;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return int'(acc);
  endfunction

  task automatic run_frame(input int cnt, input int th, input int overrun_at, input int abort_at);
    int pulses, h, n_eff, exp_pulses, v0, want;
    bit done, got;
    pulses = 0;
    done = 0;
    n_eff = (cnt == 0) ? 1 : cnt;
    exp_pulses = (th >= 0 && th < n_eff) ? th + 1 : n_eff;
    v0 = valid_cnt;
    hcount = cnt[7:0];
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    check_val("busy_in_frame", int'(busy), 1);
    if (abort_at == 0) exp_q.push_back(model_mix(cnt, th));
    while (!done) begin
      @(posedge clk); #1;
      tick = 1'b0;
      h = int'(harm);
      ready = 1'b1;
      sval = vals[h];
      too_high = (h == th);
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(posedge clk); #1;
        if (next) got = 1;
      end
      if (!got) begin
        check_val("next_pulse_seen", int'(got), 1);
        ready = 1'b0;
        return;
      end
      pulses++;
      ready = 1'b0;
      too_high = 1'b0;
      if (pulses == overrun_at) tick = 1'b1;
      if (abort_at != 0 && pulses == abort_at) begin
        check_val("abort_harm_before", int'(harm), 5);
        tick = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("abort_harm", int'(harm), 0);
        check_val("abort_busy", int'(busy), 0);
        check_val("abort_mix", int'(mix), 0);
        check_val("abort_next", int'(next), 0);
        repeat (10) @(posedge clk);
        #1;
        check_val("abort_no_valid", valid_cnt - v0, 0);
        return;
      end
      if (h == n_eff - 1 || h == th) done = 1;
    end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      tick = 1'b0;
      if (mix_valid) begin
        got = 1;
        want = (exp_q.size() != 0) ? exp_q.pop_front() : -99999;
        check_val("mix", int'($signed(mix)), want);
      end
    end
    if (!got) check_val("mix_valid_seen", int'(got), 1);
    check_val("next_pulses", pulses, exp_pulses);
    check_val("harm_end", int'(harm), 0);
    repeat (3) @(posedge clk);
    #1;
    check_val("valid_once", valid_cnt - v0, 1);
    check_val("idle_busy", int'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; ready = 1'b0; too_high = 1'b0;
    hcount = 8'd0; sval = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_harm", int'(harm), 0);
    check_val("rst_next", int'(next), 0);
    check_val("rst_mix", int'(mix), 0);
    check_val("rst_valid", int'(mix_valid), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_overrun", int'(overrun), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    vals[0] = 16'sh1000;
    run_frame(1, -1, 0, 0);
    run_frame(0, -1, 0, 0);

    vals[0] = 1000; vals[1] = 2000; vals[2] = -500;
    run_frame(3, -1, 0, 0);

    for (int i = 0; i < 8; i++) vals[i] = 1600;
    run_frame(8, 2, 0, 0);

    for (int i = 0; i < 256; i++) vals[i] = 32767;
    run_frame(255, -1, 0, 0);
    for (int i = 0; i < 256; i++) vals[i] = -32768;
    run_frame(255, -1, 0, 0);

    vals[0] = 1000; vals[1] = 2000; vals[2] = -500;
    check_val("overrun_before", int'(overrun), 0);
    run_frame(3, -1, 1, 0);
    check_val("overrun_after", int'(overrun), 1);

    for (int i = 0; i < 8; i++) vals[i] = 3200;
    run_frame(8, -1, 0, 5);
    check_val("overrun_cleared", int'(overrun), 0);

    vals[0] = 1000; vals[1] = 2000; vals[2] = -500;
    run_frame(3, -1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/harmonic_mixer.md
HARMONIC_MIXER -- requirements
Module: harmonic_mixer

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 24, signed accumulator width in bits.
REQ-002 SHALL have parameter OUT_SHIFT, default 4, arithmetic right shift applied to the accumulator before output saturation.
REQ-003 SHALL have port i_Clock, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port i_Reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port i_Sample_Tick, input, 1, single-cycle audio-rate strobe that starts a frame.
REQ-006 SHALL have port i_Harmonic_Count, input, 8, number of harmonics to sum; 0 treated as 1; sampled at frame start.
REQ-007 SHALL have port o_Harmonic, output, 8, harmonic index presented to the sample-position generator.
REQ-008 SHALL have port i_Sample_Ready, input, 1, generator indicates the sample for o_Harmonic is being produced.
REQ-009 SHALL have port i_Sample_Value, input, 16, signed sine sample; valid from the second cycle of i_Sample_Ready high.
REQ-010 SHALL have port o_Next_Sample, output, 1, single-cycle pulse: sample consumed, advance generator.
REQ-011 SHALL have port i_Freq_Too_High, input, 1, generator flags the current harmonic as above the usable band.
REQ-012 SHALL have port o_Mix, output, 16, signed saturated mix result, held between frames.
REQ-013 SHALL have port o_Mix_Valid, output, 1, single-cycle pulse when o_Mix updates.
REQ-014 SHALL have port o_Busy, output, 1, high whenever state is not IDLE.
REQ-015 SHALL have port o_Overrun, output, 1, sticky flag: tick arrived while busy.

Function
REQ-016 SHALL implement states IDLE, WAIT_READY, SETTLE, CAPTURE, RELEASE, OUTPUT.
REQ-017 SHALL, in IDLE on i_Sample_Tick: clear accumulator, latch count, keep o_Harmonic=0, go to WAIT_READY.
REQ-018 SHALL leave WAIT_READY for SETTLE only when i_Sample_Ready=1; SETTLE lasts exactly one cycle (LUT output latency).
REQ-019 SHALL, in CAPTURE, sign-extend i_Sample_Value to ACC_WIDTH and add it to the accumulator unless i_Freq_Too_High=1 (sample discarded).
REQ-020 SHALL, in CAPTURE, register o_Next_Sample=1 and the new o_Harmonic in the same edge: index+1 if more harmonics remain, else 0.
REQ-021 SHALL treat the harmonic as last when index == latched count-1 or i_Freq_Too_High=1; last goes to RELEASE then OUTPUT, otherwise to RELEASE then WAIT_READY.
REQ-022 SHALL hold o_Harmonic stable from the o_Next_Sample edge until the next CAPTURE.
REQ-023 SHALL remain in RELEASE until i_Sample_Ready=0, so a stale ready is never re-captured.
REQ-024 SHALL, in OUTPUT, set o_Mix = accumulator >>> OUT_SHIFT saturated to [-32768, 32767], pulse o_Mix_Valid for one cycle, return to IDLE.
REQ-025 SHALL ignore i_Sample_Tick when not IDLE and set o_Overrun=1; the frame in progress SHALL complete unaffected.
REQ-026 SHALL accept a tick in IDLE on the cycle immediately after OUTPUT.
REQ-027 SHALL give latency per harmonic of at least 4 cycles (WAIT_READY/SETTLE/CAPTURE/RELEASE) plus generator delay.

Reset
REQ-028 SHALL on i_Reset: state IDLE, accumulator 0, o_Harmonic 0, o_Next_Sample 0, o_Mix 0, o_Mix_Valid 0, o_Busy 0, o_Overrun 0.
REQ-029 SHALL, on reset mid-frame, discard the partial accumulation and emit no o_Mix_Valid.

Configuration
REQ-030 SHALL, with HARMONIC_ROLLOFF_EN defined, arithmetic-shift each sample right by floor(log2(index+1)) before accumulation (h0:0, h1-2:1, h3-6:2, ...).
REQ-031 SHALL, without HARMONIC_ROLLOFF_EN, accumulate samples unscaled.

Verification
REQ-032 SHALL cover: count=1, value 0x1000, tick -> one o_Next_Sample pulse, o_Harmonic ends 0, o_Mix=0x0100.
REQ-033 SHALL cover: count=3, values 1000, 2000, -500 -> o_Mix=156; with HARMONIC_ROLLOFF_EN -> o_Mix=109.
REQ-034 SHALL cover: count=8, i_Freq_Too_High raised on harmonic 2, values 1600 each -> 3 pulses, o_Mix=200, o_Harmonic=0.
REQ-035 SHALL cover: count=255, all 0x7FFF -> o_Mix=0x7FFF; all 0x8000 -> o_Mix=0x8000 (saturation).
REQ-036 SHALL cover: second tick during frame -> o_Overrun=1, exactly one o_Mix_Valid, correct result.
REQ-037 SHALL cover: reset while o_Harmonic=5 -> next cycle o_Harmonic=0, o_Busy=0, o_Mix=0, no o_Mix_Valid.
